// File: rtl/clk_en_sequencer.sv
// clk_en_sequencer
//
// Master-clock scheduler for user_core. Divides clk_mst into single-cycle CPU and PPU
// clock enables and sequences a staged reset release: the PPU leaves reset first, then
// the CPU. A synchronous soft reset restarts the release sequence without disturbing the
// divider phase. A CPU stall drops CPU enables in RUN while the PPU keeps running.
//
// Parameters
//   CPU_DIV      clk_mst cycles per clk_en_cpu pulse (integer multiple of PPU_DIV, >= 2)
//   PPU_DIV      clk_mst cycles per clk_en_ppu pulse (>= 2)
//   PPU_RST_CYC  clk_en_ppu pulses rst_en_ppu stays high once sequencing starts (>= 1)
//   CPU_RST_CYC  clk_en_cpu pulses rst_en_cpu stays high after rst_en_ppu drops (>= 1)
//
// Ports
//   clk_mst       in   master clock, rising edge
//   rst_mst       in   asynchronous active-low reset
//   soft_rst_req  in   synchronous soft-reset request
//   cpu_stall     in   level; masks clk_en_cpu while in RUN
//   clk_en_cpu    out  CPU clock enable, one clk_mst cycle wide
//   clk_en_ppu    out  PPU clock enable, one clk_mst cycle wide
//   rst_en_cpu    out  active-high CPU reset (meaningful on clk_en_cpu)
//   rst_en_ppu    out  active-high PPU reset (meaningful on clk_en_ppu)
//   seq_ready     out  high only in RUN
//   cpu_cycles    out  CPU enables issued in RUN, wraps at 2^32
//
// All outputs are registered.

module clk_en_sequencer #(
    parameter int unsigned CPU_DIV     = 12,
    parameter int unsigned PPU_DIV     = 4,
    parameter int unsigned PPU_RST_CYC = 8,
    parameter int unsigned CPU_RST_CYC = 4
) (
    input  logic        clk_mst,
    input  logic        rst_mst,
    input  logic        soft_rst_req,
    input  logic        cpu_stall,
    output logic        clk_en_cpu,
    output logic        clk_en_ppu,
    output logic        rst_en_cpu,
    output logic        rst_en_ppu,
    output logic        seq_ready,
    output logic [31:0] cpu_cycles
);

    localparam int unsigned CpuDivW   = $clog2(CPU_DIV);
    localparam int unsigned PpuDivW   = $clog2(PPU_DIV);
    localparam int unsigned MaxRstCyc = (PPU_RST_CYC > CPU_RST_CYC) ? PPU_RST_CYC : CPU_RST_CYC;
    localparam int unsigned CntW      = $clog2(MaxRstCyc + 1);

    typedef enum logic [1:0] {
        StReset,
        StPpuRst,
        StCpuRst,
        StRun
    } state_e;

    state_e              state_q;
    logic [CpuDivW-1:0]  cpu_div_q;
    logic [PpuDivW-1:0]  ppu_div_q;
    logic [CntW-1:0]     pulse_cnt_q;

    logic running;
    logic ppu_wrap;
    logic cpu_wrap;
    logic ppu_tick;
    logic cpu_issue;
    logic soft_rst;

    always_comb begin
        running   = (state_q != StReset);
        ppu_wrap  = (ppu_div_q == PpuDivW'(PPU_DIV - 1));
        cpu_wrap  = (cpu_div_q == CpuDivW'(CPU_DIV - 1));
        ppu_tick  = running && ppu_wrap;
        // Stall only masks in RUN; masked pulses are simply lost, the divider keeps phase.
        cpu_issue = running && cpu_wrap && !((state_q == StRun) && cpu_stall);
        soft_rst  = running && soft_rst_req;
    end

    // Dividers are held at zero in RESET and free-run otherwise; soft reset leaves them alone
    // so the CPU/PPU enable phase survives a soft reset.
    always_ff @(posedge clk_mst or negedge rst_mst) begin
        if (!rst_mst) begin
            cpu_div_q <= '0;
            ppu_div_q <= '0;
        end else if (!running) begin
            cpu_div_q <= '0;
            ppu_div_q <= '0;
        end else begin
            cpu_div_q <= cpu_wrap ? '0 : cpu_div_q + CpuDivW'(1);
            ppu_div_q <= ppu_wrap ? '0 : ppu_div_q + PpuDivW'(1);
        end
    end

    // Sequencer FSM with registered outputs. Pulse counting looks at the registered enables,
    // so a pulse is counted on the edge after it was issued.
    always_ff @(posedge clk_mst or negedge rst_mst) begin
        if (!rst_mst) begin
            state_q     <= StReset;
            pulse_cnt_q <= '0;
            clk_en_cpu  <= 1'b0;
            clk_en_ppu  <= 1'b0;
            rst_en_cpu  <= 1'b1;
            rst_en_ppu  <= 1'b1;
            seq_ready   <= 1'b0;
            cpu_cycles  <= '0;
        end else begin
            clk_en_ppu <= ppu_tick;
            clk_en_cpu <= cpu_issue;

            if (soft_rst) begin
                // Soft reset wins over stall and over a terminal pulse count.
                state_q     <= StPpuRst;
                pulse_cnt_q <= '0;
                rst_en_cpu  <= 1'b1;
                rst_en_ppu  <= 1'b1;
                seq_ready   <= 1'b0;
                cpu_cycles  <= '0;
            end else begin
                unique case (state_q)
                    StReset: begin
                        state_q     <= StPpuRst;
                        pulse_cnt_q <= '0;
                    end
                    StPpuRst: begin
                        if (clk_en_ppu) begin
                            if (pulse_cnt_q == CntW'(PPU_RST_CYC - 1)) begin
                                state_q     <= StCpuRst;
                                pulse_cnt_q <= '0;
                                rst_en_ppu  <= 1'b0;
                            end else begin
                                pulse_cnt_q <= pulse_cnt_q + CntW'(1);
                            end
                        end
                    end
                    StCpuRst: begin
                        if (clk_en_cpu) begin
                            if (pulse_cnt_q == CntW'(CPU_RST_CYC - 1)) begin
                                state_q     <= StRun;
                                pulse_cnt_q <= '0;
                                rst_en_cpu  <= 1'b0;
                                seq_ready   <= 1'b1;
                            end else begin
                                pulse_cnt_q <= pulse_cnt_q + CntW'(1);
                            end
                        end
                    end
                    StRun: begin
                        if (cpu_issue) begin
                            cpu_cycles <= cpu_cycles + 32'd1;
                        end
                    end
                    default: begin
                        state_q <= StReset;
                    end
                endcase
            end
        end
    end

endmodule
